// File: rtl/grid_cursor.sv
// grid_cursor: debounced four-button cursor over a GRID_COLS x GRID_ROWS grid with a registered VGA hit test.
// Optional auto-repeat on held buttons is enabled by defining GRID_CURSOR_AUTOREPEAT_EN.
module grid_cursor #(
  parameter int H_RES           = 640,
  parameter int V_RES           = 480,
  parameter int GRID_COLS       = 7,
  parameter int GRID_ROWS       = 7,
  parameter int INIT_X          = 3,
  parameter int INIT_Y          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WRAP            = 1,
  parameter logic [2:0] COLOR   = 3'b100,
`ifdef GRID_CURSOR_AUTOREPEAT_EN
  parameter int REPEAT_DELAY    = 8000,
  parameter int REPEAT_PERIOD   = 2000,
`endif
  localparam int XW = (GRID_COLS > 2) ? $clog2(GRID_COLS) : 1,
  localparam int YW = (GRID_ROWS > 2) ? $clog2(GRID_ROWS) : 1
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          button_up,
  input  logic          button_down,
  input  logic          button_left,
  input  logic          button_right,
  input  logic [10:0]   iReadCol,
  input  logic [9:0]    iReadRow,
  output logic [2:0]    RGB_out,
  output logic          show_square,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic          move_strobe
);

  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] CW = 11'(H_RES / GRID_COLS);
  localparam logic [9:0]  CH = 10'(V_RES / GRID_ROWS);
  localparam logic [XW-1:0] X_LAST = XW'(GRID_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_ROWS - 1);

  // Button order in every 4-bit vector: {right, left, down, up}
  logic [3:0]      btn_raw_s;
  logic [3:0]      sync1_r;
  logic [3:0]      sync2_r;
  logic [3:0]      level_r;
  logic [3:0]      level_d_r;
  logic [3:0]      press_s;
  logic [3:0]      event_s;
  logic [3:0]      event_r;
  logic [CNTW-1:0] db_cnt_r [4];

  logic [XW-1:0]   x_r;
  logic [YW-1:0]   y_r;
  logic [XW-1:0]   x_nxt_s;
  logic [YW-1:0]   y_nxt_s;
  logic            move_strobe_r;
  logic            show_square_r;
  logic            mv_left_s;
  logic            mv_right_s;
  logic            mv_up_s;
  logic            mv_down_s;
  logic [10:0]     col_lo_s;
  logic [10:0]     col_hi_s;
  logic [9:0]      row_lo_s;
  logic [9:0]      row_hi_s;
  logic            hit_s;

  assign btn_raw_s = {button_right, button_left, button_down, button_up};
  assign press_s   = level_r & ~level_d_r;

  // Synchronise, debounce and register the per-button move events
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_r   <= 4'b0000;
      sync2_r   <= 4'b0000;
      level_r   <= 4'b0000;
      level_d_r <= 4'b0000;
      event_r   <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r   <= btn_raw_s;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      event_r   <= event_s;
      for (int i = 0; i < 4; i++) begin
        // The count measures how long the synced sample has disagreed with the accepted level
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == CNT_LAST) begin
          db_cnt_r[i] <= '0;
          level_r[i]  <= sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
        end
      end
    end
  end

`ifdef GRID_CURSOR_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

  logic [RW-1:0] rep_cnt_r [4];
  logic [3:0]    rep_armed_r;
  logic [3:0]    rep_fire_s;

  // A repeat fires once the held time since the last event reaches the delay, then the period
  always_comb begin
    rep_fire_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (rep_armed_r[i]) begin
        rep_fire_s[i] = level_r[i] & ~press_s[i] & (rep_cnt_r[i] == R_PERIOD);
      end else begin
        rep_fire_s[i] = level_r[i] & ~press_s[i] & (rep_cnt_r[i] == R_DELAY);
      end
    end
  end

  // Per-button repeat timers, cleared whenever the debounced level is low
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      rep_armed_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        rep_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!level_r[i]) begin
          rep_cnt_r[i]   <= '0;
          rep_armed_r[i] <= 1'b0;
        end else if (press_s[i]) begin
          rep_cnt_r[i]   <= RW'(1);
          rep_armed_r[i] <= 1'b0;
        end else if (rep_fire_s[i]) begin
          rep_cnt_r[i]   <= RW'(1);
          rep_armed_r[i] <= 1'b1;
        end else begin
          rep_cnt_r[i]   <= rep_cnt_r[i] + 1'b1;
        end
      end
    end
  end

  assign event_s = press_s | rep_fire_s;
`else
  assign event_s = press_s;
`endif

  assign mv_up_s    = event_r[0] & ~event_r[1];
  assign mv_down_s  = event_r[1] & ~event_r[0];
  assign mv_left_s  = event_r[2] & ~event_r[3];
  assign mv_right_s = event_r[3] & ~event_r[2];

  // Next cursor position with wrap or saturation at the grid edges
  always_comb begin
    x_nxt_s = x_r;
    y_nxt_s = y_r;
    if (mv_left_s) begin
      if (x_r == '0) begin
        x_nxt_s = (WRAP != 0) ? X_LAST : x_r;
      end else begin
        x_nxt_s = x_r - 1'b1;
      end
    end else if (mv_right_s) begin
      if (x_r == X_LAST) begin
        x_nxt_s = (WRAP != 0) ? '0 : x_r;
      end else begin
        x_nxt_s = x_r + 1'b1;
      end
    end else begin
      x_nxt_s = x_r;
    end
    if (mv_up_s) begin
      if (y_r == '0) begin
        y_nxt_s = (WRAP != 0) ? Y_LAST : y_r;
      end else begin
        y_nxt_s = y_r - 1'b1;
      end
    end else if (mv_down_s) begin
      if (y_r == Y_LAST) begin
        y_nxt_s = (WRAP != 0) ? '0 : y_r;
      end else begin
        y_nxt_s = y_r + 1'b1;
      end
    end else begin
      y_nxt_s = y_r;
    end
  end

  // Cell bounds of the current cursor; leftover pixels lie beyond the last cell and never hit
  assign col_lo_s = CW * 11'(x_r);
  assign col_hi_s = col_lo_s + CW;
  assign row_lo_s = CH * 10'(y_r);
  assign row_hi_s = row_lo_s + CH;
  assign hit_s    = (iReadCol >= col_lo_s) && (iReadCol < col_hi_s) &&
                    (iReadRow >= row_lo_s) && (iReadRow < row_hi_s);

  // Cursor state, move pulse and registered hit test
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r           <= XW'(INIT_X);
      y_r           <= YW'(INIT_Y);
      move_strobe_r <= 1'b0;
      show_square_r <= 1'b0;
    end else begin
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      move_strobe_r <= (x_nxt_s != x_r) || (y_nxt_s != y_r);
      show_square_r <= hit_s;
    end
  end

  assign RGB_out     = COLOR;
  assign show_square = show_square_r;
  assign move_strobe = move_strobe_r;
  assign cursor_x    = x_r;
  assign cursor_y    = y_r;

endmodule

// File: tb/tb_grid_cursor.sv
// Scoreboard bench for grid_cursor: a wrapping and a saturating instance share the buttons;
// a grid-arithmetic model predicts each move and its edge, and a monitor checks strobes and hits.
module tb_grid_cursor;

  localparam int D    = 16;
  localparam int COLS = 7;
  localparam int ROWS = 7;
  localparam int CW   = 640 / COLS;
  localparam int CH   = 480 / ROWS;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        button_up, button_down, button_left, button_right;
  logic [10:0] iReadCol;
  logic [9:0]  iReadRow;

  logic [2:0]  rgb_w, rgb_s;
  logic        show_w, show_s, ms_w, ms_s;
  logic [2:0]  cx_w, cy_w, cx_s, cy_s;

  typedef struct {int x; int y; int at_edge;} exp_t;
  exp_t q_w[$];
  exp_t q_s[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int wx, wy, sx, sy;          // stimulus-side model (runs ahead of the DUT)
  int px = 3, py = 4;          // monitor-side position of the wrapping DUT
  int ppx, ppy, pcol, prow;
  bit prev_valid = 1'b0;

  grid_cursor #(.WRAP(1)) dut_wrap (
    .Clock(Clock), .Reset_n(Reset_n),
    .button_up(button_up), .button_down(button_down),
    .button_left(button_left), .button_right(button_right),
    .iReadCol(iReadCol), .iReadRow(iReadRow),
    .RGB_out(rgb_w), .show_square(show_w),
    .cursor_x(cx_w), .cursor_y(cy_w), .move_strobe(ms_w)
  );

  grid_cursor #(.WRAP(0)) dut_sat (
    .Clock(Clock), .Reset_n(Reset_n),
    .button_up(button_up), .button_down(button_down),
    .button_left(button_left), .button_right(button_right),
    .iReadCol(iReadCol), .iReadRow(iReadRow),
    .RGB_out(rgb_s), .show_square(show_s),
    .cursor_x(cx_s), .cursor_y(cy_s), .move_strobe(ms_s)
  );

  always #20 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, cyc);
  endtask

  function automatic int clampv(input int v, input int hi);
    if (v < 0) return 0;
    else if (v > hi) return hi;
    else return v;
  endfunction

  // Hold mask m for 'hold' edges, predict the outcome, then release long enough to settle
  task automatic press(input logic [3:0] m, input int hold);
    int k, dx, dy, nx, ny;
    exp_t e;
    {button_right, button_left, button_down, button_up} = m;
    k  = cyc + 1;
    dx = int'(m[3]) - int'(m[2]);
    dy = int'(m[1]) - int'(m[0]);
    if (hold >= D && (dx != 0 || dy != 0)) begin
      wx = (wx + dx + COLS) % COLS;
      wy = (wy + dy + ROWS) % ROWS;
      e.x = wx; e.y = wy; e.at_edge = k + D + 3;
      q_w.push_back(e);
      nx = clampv(sx + dx, COLS - 1);
      ny = clampv(sy + dy, ROWS - 1);
      if (nx != sx || ny != sy) begin
        sx = nx; sy = ny;
        e.x = sx; e.y = sy;
        q_s.push_back(e);
      end
    end
    repeat (hold) @(posedge Clock);
    #1;
    {button_right, button_left, button_down, button_up} = 4'b0000;
    repeat (D + 6) @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_x", int'(cx_w), 3);
    check("rst_y", int'(cy_w), 4);
    check("rst_show", int'(show_w), 0);
    check("rst_strobe", int'(ms_w), 0);
    check("rst_sat_x", int'(cx_s), 3);
    check("rst_sat_y", int'(cy_s), 4);
    check("rst_sat_strobe", int'(ms_s), 0);
  endtask

  // Scan position driver, biased towards the current cursor cell
  initial begin
    int c, r;
    iReadCol = 11'd0;
    iReadRow = 10'd0;
    forever begin
      @(posedge Clock);
      #1;
      if ($urandom_range(0, 1) == 0) begin
        c = CW * px + int'($urandom_range(0, CW + 3)) - 2;
        r = CH * py + int'($urandom_range(0, CH + 3)) - 2;
      end else begin
        c = int'($urandom_range(0, 799));
        r = int'($urandom_range(0, 524));
      end
      if (c < 0) c = 0;
      if (r < 0) r = 0;
      iReadCol = 11'(c);
      iReadRow = 10'(r);
    end
  end

  // Monitor: hit test against the previous cycle's scan, strobes against the scoreboards
  always @(negedge Clock) begin
    exp_t e;
    int eh;
    if (!Reset_n) begin
      prev_valid = 1'b0;
      px = 3;
      py = 4;
    end else begin
      if (prev_valid) begin
        eh = int'(pcol >= CW * ppx && pcol < CW * (ppx + 1) &&
                  prow >= CH * ppy && prow < CH * (ppy + 1));
        check("show_square", int'(show_w), eh);
      end
      if (ms_w) begin
        if (q_w.size() == 0) begin
          check("wrap_unexpected_strobe", 1, 0);
        end else begin
          e = q_w.pop_front();
          check("wrap_edge", cyc, e.at_edge);
          check("wrap_x", int'(cx_w), e.x);
          check("wrap_y", int'(cy_w), e.y);
          px = e.x;
          py = e.y;
        end
      end else if (q_w.size() > 0 && q_w[0].at_edge < cyc) begin
        e = q_w.pop_front();
        check("wrap_missing_strobe", cyc, e.at_edge);
        px = e.x;
        py = e.y;
      end
      if (ms_s) begin
        if (q_s.size() == 0) begin
          check("sat_unexpected_strobe", 1, 0);
        end else begin
          e = q_s.pop_front();
          check("sat_edge", cyc, e.at_edge);
          check("sat_x", int'(cx_s), e.x);
          check("sat_y", int'(cy_s), e.y);
        end
      end else if (q_s.size() > 0 && q_s[0].at_edge < cyc) begin
        e = q_s.pop_front();
        check("sat_missing_strobe", cyc, e.at_edge);
      end
      pcol = int'(iReadCol);
      prow = int'(iReadRow);
      ppx  = px;
      ppy  = py;
      prev_valid = 1'b1;
    end
  end

  initial begin
    exp_t e;
    int k, hold;
    Reset_n = 1'b0;
    {button_right, button_left, button_down, button_up} = 4'b0000;
    wx = 3; wy = 4; sx = 3; sy = 4;
    repeat (3) @(posedge Clock);
    #1;
    check_reset_state();
    check("rgb", int'(rgb_w), 4);
    Reset_n = 1'b1;
    repeat (4) @(posedge Clock);
    #1;

    press(4'b1000, 10);   // glitch on right: no move
    press(4'b1000, 40);   // right: x 3->4 at edge k+19
    press(4'b0011, 30);   // up+down cancel
    press(4'b0101, 30);   // up+left: (3,3)
    repeat (4) press(4'b1000, 20);  // to x=6 then wrap to 0; saturating instance sticks at 6
    repeat (4) press(4'b0001, 20);  // up to 0 then wrap; saturating instance sticks at 0

    // Reset in the middle of a debounce with down still held afterwards
    {button_right, button_left, button_down, button_up} = 4'b0010;
    repeat (8) @(posedge Clock);
    #1;
    Reset_n = 1'b0;
    #5;
    check_reset_state();
    repeat (2) @(posedge Clock);
    #1;
    check_reset_state();
    q_w.delete();
    q_s.delete();
    wx = 3; wy = 4; sx = 3; sy = 4;
    Reset_n = 1'b1;
    k = cyc + 1;
    wy = 5; sy = 5;
    e.x = 3; e.y = 5; e.at_edge = k + D + 3;
    q_w.push_back(e);
    q_s.push_back(e);
    repeat (30) @(posedge Clock);
    #1;
    {button_right, button_left, button_down, button_up} = 4'b0000;
    repeat (D + 6) @(posedge Clock);
    #1;

    // Randomised presses and glitches
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) hold = int'($urandom_range(1, D - 1));
      else hold = int'($urandom_range(D, D + 12));
      press(4'($urandom_range(0, 15)), hold);
    end

    repeat (30) @(posedge Clock);
    #1;
    check("wrap_queue_drained", q_w.size(), 0);
    check("sat_queue_drained", q_s.size(), 0);
    check("rgb_end", int'(rgb_s), 4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
